// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART ALU slice.
//   - default byte / opcode widths
//   - FSM state encoding for uart_alu_interface
//   - the eight ALU opcode values (6-bit)
package uart_pkg;

  localparam int unsigned NB_DATA_DEF = 8;
  localparam int unsigned NB_OP_DEF   = 6;

  typedef enum logic [2:0] {
    S_WAIT_A   = 3'd0,
    S_WAIT_B   = 3'd1,
    S_WAIT_OP  = 3'd2,
    S_START_TX = 3'd3,
    S_WAIT_TX  = 3'd4
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/uart_alu_interface_alu.sv
// alu: purely combinational ALU used by uart_alu_interface.
// Ports:
//   i_a      [NB_DATA-1:0]  operand A
//   i_b      [NB_DATA-1:0]  operand B (unsigned shift amount for shifts)
//   i_op     [NB_OP-1:0]    opcode
//   o_result [NB_DATA-1:0]  result; 0 for unknown opcodes
// ADD/SUB wrap modulo 2^NB_DATA. Shift amounts >= NB_DATA saturate:
// SRL gives 0, SRA gives a full sign fill.
module alu
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_OP   = NB_OP_DEF
) (
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  input  logic [NB_OP-1:0]   i_op,
  output logic [NB_DATA-1:0] o_result
);

  localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);

  logic shift_sat;

  assign shift_sat = (i_b >= SHIFT_LIMIT);

  always_comb begin
    o_result = '0;
    case (i_op)
      NB_OP'(OP_ADD): o_result = i_a + i_b;
      NB_OP'(OP_SUB): o_result = i_a - i_b;
      NB_OP'(OP_AND): o_result = i_a & i_b;
      NB_OP'(OP_OR):  o_result = i_a | i_b;
      NB_OP'(OP_XOR): o_result = i_a ^ i_b;
      NB_OP'(OP_NOR): o_result = ~(i_a | i_b);
      NB_OP'(OP_SRA): begin
        if (shift_sat)
          o_result = {NB_DATA{i_a[NB_DATA-1]}};
        else
          o_result = $signed(i_a) >>> i_b;
      end
      NB_OP'(OP_SRL): begin
        if (shift_sat)
          o_result = '0;
        else
          o_result = i_a >> i_b;
      end
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: sits between UART rx and tx. Collects operand A,
// operand B and an opcode byte, computes the ALU result, pulses the
// transmitter start for one cycle and waits for its done pulse.
// Ports:
//   i_clk       system clock
//   i_rst       synchronous reset, active-high (priority over all inputs)
//   i_rx_done   one-cycle pulse, i_rx_data valid
//   i_rx_data   received byte
//   i_tx_done   one-cycle pulse, transmitter finished
//   o_tx_start  one-cycle pulse, start transmitting o_tx_data
//   o_tx_data   registered result byte
//   o_busy      high while a result is pending or in transmission
//   o_overrun   (only with UART_ALU_OVERRUN_EN) sticky flag, set when a
//               byte arrives while busy; cleared only by i_rst
// Optional feature macro: UART_ALU_OVERRUN_EN
module uart_alu_interface
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_OP   = NB_OP_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy
`ifdef UART_ALU_OVERRUN_EN
  ,
  output logic               o_overrun
`endif
);

  state_t             state;
  state_t             next_state;
  logic [NB_DATA-1:0] a_reg;
  logic [NB_DATA-1:0] b_reg;
  logic [NB_DATA-1:0] tx_data_reg;
  logic [NB_DATA-1:0] alu_result;

  // The opcode is taken straight from the incoming byte so the result can
  // be registered on the same edge the opcode arrives.
  alu #(
    .NB_DATA (NB_DATA),
    .NB_OP   (NB_OP)
  ) u_alu (
    .i_a      (a_reg),
    .i_b      (b_reg),
    .i_op     (i_rx_data[NB_OP-1:0]),
    .o_result (alu_result)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_WAIT_A;
      a_reg       <= '0;
      b_reg       <= '0;
      tx_data_reg <= '0;
    end else begin
      state <= next_state;
      if (i_rx_done) begin
        case (state)
          S_WAIT_A:  a_reg       <= i_rx_data;
          S_WAIT_B:  b_reg       <= i_rx_data;
          S_WAIT_OP: tx_data_reg <= alu_result;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    next_state = state;
    o_tx_start = 1'b0;
    o_busy     = 1'b0;
    case (state)
      S_WAIT_A:   if (i_rx_done) next_state = S_WAIT_B;
      S_WAIT_B:   if (i_rx_done) next_state = S_WAIT_OP;
      S_WAIT_OP:  if (i_rx_done) next_state = S_START_TX;
      S_START_TX: begin
        o_tx_start = 1'b1;
        o_busy     = 1'b1;
        next_state = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        o_busy = 1'b1;
        // A byte arriving together with i_tx_done is dropped, not taken as A.
        if (i_tx_done) next_state = S_WAIT_A;
      end
      default:    next_state = S_WAIT_A;
    endcase
  end

  assign o_tx_data = tx_data_reg;

`ifdef UART_ALU_OVERRUN_EN
  logic overrun_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      overrun_reg <= 1'b0;
    else if (i_rx_done && (state == S_START_TX || state == S_WAIT_TX))
      overrun_reg <= 1'b1;
  end

  assign o_overrun = overrun_reg;
`endif

endmodule
